// File: rtl/ui_bus_arbiter_if.sv
// Bundle of requester-side and UiController-side signals around ui_bus_arbiter.
// slave = arbiter view, master = requesters plus UiController view.
interface ui_bus_arbiter_if #(
    parameter int DBITS = 32,
    parameter int NREQ  = 2
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       wr;
    logic [2*NREQ-1:0]     dev;
    logic [DBITS*NREQ-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic [DBITS-1:0]      rdata;
    logic                  busy;
    logic [1:0]            ui_device;
    logic                  ui_wrtEn;
    logic [DBITS-1:0]      ui_in;
    logic [DBITS-1:0]      ui_out;

    modport slave (
        input  req, wr, dev, wdata, ui_out,
        output gnt, done, err, rdata, busy, ui_device, ui_wrtEn, ui_in
    );

    modport master (
        output req, wr, dev, wdata, ui_out,
        input  gnt, done, err, rdata, busy, ui_device, ui_wrtEn, ui_in
    );
endinterface

// File: rtl/ui_bus_arbiter.sv
// Round-robin arbiter sharing the single UiController port among NREQ requesters;
// each grant performs one fixed IDLE -> ACCESS -> RESP transaction.
module ui_bus_arbiter #(
    parameter int DBITS = 32,
    parameter int NREQ  = 2
) (
    input  logic             clk,
    input  logic             reset,
    ui_bus_arbiter_if.slave  bus
);
    localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR = NREQ;

    localparam logic [1:0] UI_KEY  = 2'd0;
    localparam logic [1:0] UI_SW   = 2'd1;
    localparam logic [1:0] UI_LEDR = 2'd2;
    localparam logic [1:0] UI_HEX  = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    win_q, win_d;
    logic             wr_q, wr_d;
    logic             err_q, err_d;
    logic [1:0]       dev_q, dev_d;
    logic [DBITS-1:0] wdata_q, wdata_d;
    logic [DBITS-1:0] rdata_q, rdata_d;

    logic [IW-1:0]    pick;
    logic [IW-1:0]    cand;
    logic             any_req;
    logic             ro_dev;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        pick    = ptr_q;
        cand    = ptr_q;
        any_req = 1'b0;
        for (int unsigned i = 1; i <= NR; i++) begin
            cand = IW'((32'(ptr_q) + i) % NR);
            if (!any_req && bus.req[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            win_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            dev_q   <= UI_KEY;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            dev_q   <= dev_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        wr_d    = wr_q;
        err_d   = err_q;
        dev_d   = dev_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    win_d   = pick;
                    wr_d    = bus.wr[pick];
                    dev_d   = bus.dev[2*int'(pick) +: 2];
                    wdata_d = bus.wdata[DBITS*int'(pick) +: DBITS];
                    err_d   = bus.wr[pick] &&
                              (bus.dev[2*int'(pick) +: 2] == UI_KEY ||
                               bus.dev[2*int'(pick) +: 2] == UI_SW);
                end
            end
            ACCESS: begin
                rdata_d = bus.ui_out;
                state_d = RESP;
            end
            RESP: begin
                ptr_d   = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ro_dev = (dev_q == UI_KEY) || (dev_q == UI_SW);

    // ui_device/ui_in come straight from the captured operands, so they hold between transactions.
    always_comb begin
        bus.gnt       = '0;
        bus.done      = '0;
        bus.err       = 1'b0;
        bus.busy      = (state_q != IDLE);
        bus.rdata     = rdata_q;
        bus.ui_device = dev_q;
        bus.ui_in     = wdata_q;
        bus.ui_wrtEn  = 1'b0;
        case (state_q)
            ACCESS: begin
                bus.gnt[win_q] = 1'b1;
                bus.ui_wrtEn   = wr_q && !ro_dev;
            end
            RESP: begin
                bus.gnt[win_q]  = 1'b1;
                bus.done[win_q] = 1'b1;
                bus.err         = err_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ui_bus_arbiter.sv
// Directed bench for ui_bus_arbiter with a small behavioural UiController model.
module tb_ui_bus_arbiter;
    localparam int DBITS = 32;
    localparam int NREQ  = 2;

    localparam logic [1:0] UI_KEY  = 2'd0;
    localparam logic [1:0] UI_SW   = 2'd1;
    localparam logic [1:0] UI_LEDR = 2'd2;
    localparam logic [1:0] UI_HEX  = 2'd3;

    typedef struct {
        logic [1:0]  req;
        logic        wr;
        logic [1:0]  dev;
        logic [31:0] wdata;
        logic [1:0]  exp_gnt;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_wen;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ui_bus_arbiter_if #(.DBITS(DBITS), .NREQ(NREQ)) bus ();
    ui_bus_arbiter #(.DBITS(DBITS), .NREQ(NREQ)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] sw_v, key_v, ledr_v, hex_v;
    assign sw_v  = 32'h155;
    assign key_v = 32'h0000_000A;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            ledr_v <= '0;
            hex_v  <= '0;
        end else if (bus.ui_wrtEn) begin
            case (bus.ui_device)
                UI_LEDR: ledr_v <= bus.ui_in;
                UI_HEX:  hex_v  <= bus.ui_in;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (bus.ui_device)
            UI_KEY:  bus.ui_out = key_v;
            UI_SW:   bus.ui_out = sw_v;
            UI_LEDR: bus.ui_out = ledr_v;
            default: bus.ui_out = hex_v;
        endcase
    end

    int n_chk  = 0;
    int n_fail = 0;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction; the idle requester gets conflicting operands.
    task automatic run_vec(input vec_t v, input int n);
        int wen;
        bus.req = v.req;
        if (v.req[0]) begin
            bus.wr    = {~v.wr, v.wr};
            bus.dev   = {~v.dev, v.dev};
            bus.wdata = {32'hDEAD_BEEF, v.wdata};
        end else begin
            bus.wr    = {v.wr, ~v.wr};
            bus.dev   = {v.dev, ~v.dev};
            bus.wdata = {v.wdata, 32'hDEAD_BEEF};
        end
        tick();
        chk($sformatf("v%0d_acc_gnt", n), 32'(bus.gnt), 32'(v.exp_gnt));
        chk($sformatf("v%0d_acc_done", n), 32'(bus.done), 32'h0);
        chk($sformatf("v%0d_acc_dev", n), 32'(bus.ui_device), 32'(v.dev));
        wen = int'(bus.ui_wrtEn);
        tick();
        chk($sformatf("v%0d_resp_gnt", n), 32'(bus.gnt), 32'(v.exp_gnt));
        chk($sformatf("v%0d_resp_done", n), 32'(bus.done), 32'(v.exp_gnt));
        chk($sformatf("v%0d_resp_err", n), 32'(bus.err), 32'(v.exp_err));
        chk($sformatf("v%0d_rdata", n), bus.rdata, v.exp_rdata);
        wen += int'(bus.ui_wrtEn);
        bus.req = '0;
        tick();
        wen += int'(bus.ui_wrtEn);
        chk($sformatf("v%0d_idle_busy", n), 32'(bus.busy), 32'h0);
        chk($sformatf("v%0d_idle_done", n), 32'(bus.done), 32'h0);
        chk($sformatf("v%0d_rdata_held", n), bus.rdata, v.exp_rdata);
        chk($sformatf("v%0d_wen_cycles", n), 32'(wen), 32'(v.exp_wen));
    endtask

    initial begin
        vecs[0] = '{2'b01, 1'b0, UI_SW,   32'h0,   2'b01, 32'h155, 1'b0, 0};
        vecs[1] = '{2'b10, 1'b1, UI_LEDR, 32'h2AA, 2'b10, 32'h2AA, 1'b0, 1};
        vecs[2] = '{2'b01, 1'b1, UI_KEY,  32'hF,   2'b01, 32'hA,   1'b1, 0};
        vecs[3] = '{2'b10, 1'b1, UI_HEX,  32'h3F,  2'b10, 32'h3F,  1'b0, 1};
        vecs[4] = '{2'b01, 1'b0, UI_LEDR, 32'h0,   2'b01, 32'h2AA, 1'b0, 0};
        vecs[5] = '{2'b10, 1'b1, UI_SW,   32'h123, 2'b10, 32'h155, 1'b1, 0};
        vecs[6] = '{2'b01, 1'b0, UI_HEX,  32'h0,   2'b01, 32'h3F,  1'b0, 0};

        bus.req   = '0;
        bus.wr    = '0;
        bus.dev   = '0;
        bus.wdata = '0;
        #1 reset = 1'b0;
        #2;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_wrten", 32'(bus.ui_wrtEn), 32'h0);
        chk("rst_device", 32'(bus.ui_device), 32'(UI_KEY));
        chk("rst_ui_in", bus.ui_in, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        chk("idle_no_req_busy", 32'(bus.busy), 32'h0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
            if (i == 1) chk("led_after_write", ledr_v, 32'h2AA);
        end

        // Both requesting continuously from reset: strict alternation on 3-cycle spacing.
        reset     = 1'b0;
        bus.req   = 2'b11;
        bus.wr    = 2'b00;
        bus.dev   = {UI_SW, UI_SW};
        bus.wdata = '0;
        tick();
        chk("rr_rst_gnt", 32'(bus.gnt), 32'h0);
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            logic [1:0] eg, ed;
            tick();
            eg = '0;
            ed = '0;
            if (c % 3 != 2) eg = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            if (c % 3 == 1) ed = eg;
            chk($sformatf("rr_c%0d_gnt", c), 32'(bus.gnt), 32'(eg));
            chk($sformatf("rr_c%0d_done", c), 32'(bus.done), 32'(ed));
        end

        // Reset landing in the middle of requester 1's write ACCESS.
        bus.wr    = 2'b10;
        bus.dev   = {UI_LEDR, UI_SW};
        bus.wdata = {32'h0F0, 32'h0};
        tick();
        chk("mr_acc0_gnt", 32'(bus.gnt), 32'h1);
        tick();
        tick();
        tick();
        chk("mr_acc1_gnt", 32'(bus.gnt), 32'h2);
        chk("mr_acc1_wrten", 32'(bus.ui_wrtEn), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mr_gnt", 32'(bus.gnt), 32'h0);
        chk("mr_done", 32'(bus.done), 32'h0);
        chk("mr_wrten", 32'(bus.ui_wrtEn), 32'h0);
        chk("mr_busy", 32'(bus.busy), 32'h0);
        chk("mr_device", 32'(bus.ui_device), 32'(UI_KEY));
        chk("mr_ui_in", bus.ui_in, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("mr_first_gnt", 32'(bus.gnt), 32'h1);
        tick();
        chk("mr_first_done", 32'(bus.done), 32'h1);
        bus.req = '0;
        tick();
        tick();
        chk("mr_settle_busy", 32'(bus.busy), 32'h0);

        // Requester 1 drops req during ACCESS: transaction still completes once.
        bus.req = 2'b10;
        bus.wr  = 2'b00;
        bus.dev = {UI_SW, UI_SW};
        tick();
        chk("drop_acc_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        tick();
        chk("drop_resp_done", 32'(bus.done), 32'h2);
        chk("drop_rdata", bus.rdata, 32'h155);
        tick();
        chk("drop_idle_gnt", 32'(bus.gnt), 32'h0);
        chk("drop_idle_done", 32'(bus.done), 32'h0);
        tick();
        chk("drop_idle2_gnt", 32'(bus.gnt), 32'h0);
        chk("drop_idle2_busy", 32'(bus.busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
